// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at launch and committed after a fixed busy window.
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mul_divop,
    input  logic        hilo,
    input  logic        hilowrite,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic        dz_q, dz_d;

    logic [63:0]        prod_u;
    logic signed [63:0] prod_s;
    logic        sgn;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] q_mag, r_mag, quot, rem;
    logic [31:0] res_hi, res_lo;

    assign prod_u = {32'd0, A} * {32'd0, B};
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});

    // One unsigned divider on magnitudes serves both div and divu.
    assign sgn    = mul_divop[0];
    assign a_neg  = sgn & A[31];
    assign b_neg  = sgn & B[31];
    assign a_mag  = a_neg ? (~A + 32'd1) : A;
    assign b_mag  = b_neg ? (~B + 32'd1) : B;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        unique case (mul_divop[1:0])
            2'b00: {res_hi, res_lo} = prod_u;
            2'b01: {res_hi, res_lo} = prod_s;
            2'b10: {res_hi, res_lo} = {rem, quot};
            2'b11: {res_hi, res_lo} = {rem, quot};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (!mul_divop[2]) begin
                        phi_d   = res_hi;
                        plo_d   = res_lo;
                        dz_d    = mul_divop[1] && (B == 32'd0);
                        cnt_d   = mul_divop[1] ? DIV_N : MUL_N;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end else if (hilowrite) begin
                    if (hilo) hi_d = A;
                    else      lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (!dz_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_mul_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mul_divop;
    logic        hilo;
    logic        hilowrite;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mul_div_unit #(.MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .mul_divop(mul_divop),
        .hilo(hilo), .hilowrite(hilowrite), .A(A), .B(B),
        .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic straight from the op definitions.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
            3'd1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
            3'd2: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd3: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; mul_divop = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int chg);
        logic [31:0] h0, l0;
        h0 = HI; l0 = LO; n = 0; chg = 0;
        while (busy && n < 200) begin
            if (HI !== h0 || LO !== l0) chg++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_chk(input string nm, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el);
        int n, chg;
        issue(op, a, b);
        wait_done(n, chg);
        chk({nm, "_cycles"}, 32'(n), op[1] ? 32'(DC) : 32'(MC));
        chk({nm, "_hold"}, 32'(chg), 32'd0);
        chk({nm, "_hi"}, HI, eh);
        chk({nm, "_lo"}, LO, el);
    endtask

    initial begin
        vec_t vt[$];
        int n, chg;
        logic [2:0]  op;
        logic [31:0] a, b;

        vt.push_back('{3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE});
        vt.push_back('{3'd0, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE});
        vt.push_back('{3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD});
        vt.push_back('{3'd2, 32'd7,        32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD});
        vt.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000});
        vt.push_back('{3'd2, 32'd100,      32'd7, 32'd2, 32'd14});
        vt.push_back('{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD});
        vt.push_back('{3'd1, 32'h00010000, 32'h00010000, 32'd1, 32'd0});
        vt.push_back('{3'd3, 32'd5,        32'd0, 32'd1, 32'd0});

        reset = 1'b1; start = 1'b0; mul_divop = 3'd0;
        hilo = 1'b0; hilowrite = 1'b0; A = 32'd0; B = 32'd0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);

        foreach (vt[i]) run_chk($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo);
        m_hi = HI; m_lo = LO;
        m_hi = 32'd1; m_lo = 32'd0;

        // mthi then mtlo
        hilowrite = 1'b1; hilo = 1'b1; A = 32'h1234;
        @(negedge clk);
        hilowrite = 1'b0;
        chk("mthi_hi", HI, 32'h1234);
        chk("mthi_busy", 32'(busy), 32'd0);
        chk("mthi_lo", LO, m_lo);
        hilowrite = 1'b1; hilo = 1'b0; A = 32'h5678;
        @(negedge clk);
        hilowrite = 1'b0;
        chk("mtlo_lo", LO, 32'h5678);
        chk("mtlo_hi", HI, 32'h1234);

        // mtlo together with start: only the multiply lands
        hilowrite = 1'b1; hilo = 1'b0;
        issue(3'd0, 32'd3, 32'd4);
        hilowrite = 1'b0;
        chk("mix_lo_held", LO, 32'h5678);
        wait_done(n, chg);
        chk("mix_cycles", 32'(n), 32'(MC));
        chk("mix_hi", HI, 32'd0);
        chk("mix_lo", LO, 32'd12);

        // reset in the third busy cycle aborts the multiply
        issue(3'd1, 32'hFFFFFFFF, 32'd7);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) n++;
        end
        chk("abort_nocommit", 32'(n), 32'd0);

        // start and mthi while busy are both ignored
        issue(3'd1, 32'hFFFFFFFF, 32'd3);
        @(negedge clk);
        start = 1'b1; mul_divop = 3'd2; A = 32'd100; B = 32'd5;
        hilowrite = 1'b1; hilo = 1'b1;
        @(negedge clk);
        start = 1'b0; hilowrite = 1'b0;
        wait_done(n, chg);
        chk("busy_start_cycles", 32'(n + 2), 32'(MC));
        chk("busy_start_hi", HI, 32'hFFFFFFFF);
        chk("busy_start_lo", LO, 32'hFFFFFFFD);

        // back-to-back launches
        run_chk("b2b0", 3'd2, 32'd50, 32'd6, 32'd2, 32'd8);
        run_chk("b2b1", 3'd0, 32'd9, 32'd9, 32'd0, 32'd81);

        // reserved opcode never raises busy
        issue(3'd4, 32'd5, 32'd5);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (busy !== 1'b0) n++;
            @(negedge clk);
        end
        chk("rsvd_busy", 32'(n), 32'd0);
        chk("rsvd_hi", HI, 32'd0);
        chk("rsvd_lo", LO, 32'd81);

        m_hi = 32'd0; m_lo = 32'd81;
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'(($urandom_range(0, 1) == 0) ? 1 : -1);
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 300));
                default: ;
            endcase
            model(op, a, b);
            run_chk($sformatf("rnd%0d", k), op, a, b, m_hi, m_lo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
